// File: rtl/sram_150b_512_ctrl.sv
// Initiator-side controller for a 150b x 512 single-port OpenRAM macro: registered macro pins,
// 2-cycle read capture into a credit-protected response FIFO, and a whole-array zero-fill.
module sram_150b_512_ctrl #(
  parameter int unsigned DATA_WIDTH = 150,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned PtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clear_ptr_q;
  logic                  clear_done_q;
  logic [CntW-1:0]       outstanding_q;
  logic                  rd_v1_q, rd_v2_q;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PtrW:0]         wr_ptr_q, rd_ptr_q;

  logic accept, accept_rd, pop, push, fifo_full;

  assign clear_busy = (state_q == StClear);
  assign clear_done = clear_done_q;
  // Ready is forced low while reset is sampled so nothing is accepted at a resetting edge.
  assign req_ready  = rst_n && !clear_busy && (outstanding_q < CntW'(RSP_DEPTH));
  assign accept     = req_valid && req_ready;
  assign accept_rd  = accept && !req_we;

  assign rsp_valid  = (wr_ptr_q != rd_ptr_q);
  assign rsp_rdata  = fifo_q[rd_ptr_q[PtrW-1:0]];
  assign pop        = rsp_valid && rsp_ready;
  assign push       = rd_v2_q;
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  // Macro pins; accepted requests and clear steps never coincide.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
    end else if (accept) begin
      csb0  <= 1'b0;
      web0  <= !req_we;
      addr0 <= req_addr;
      din0  <= req_wdata;
    end else if (clear_busy) begin
      csb0  <= 1'b0;
      web0  <= 1'b0;
      addr0 <= clear_ptr_q;
      din0  <= '0;
    end else begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      clear_ptr_q  <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clear_start) begin
            state_q     <= StClear;
            clear_ptr_q <= '0;
          end
        end
        StClear: begin
          clear_ptr_q <= clear_ptr_q + ADDR_WIDTH'(1);
          if (clear_ptr_q == '1) begin
            state_q      <= StIdle;
            clear_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      unique case ({accept_rd, pop})
        2'b10:   outstanding_q <= outstanding_q + CntW'(1);
        2'b01:   outstanding_q <= outstanding_q - CntW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Stage-2 valid lines up with dout0 driven at the previous negedge.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      rd_v1_q  <= 1'b0;
      rd_v2_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      rd_v1_q <= accept_rd;
      rd_v2_q <= rd_v1_q;
      if (push) wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk0) begin
    if (rst_n && push) fifo_q[wr_ptr_q[PtrW-1:0]] <= dout0;
  end

  assert property (@(posedge clk0) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_sram_150b_512_ctrl.sv
// Bench for sram_150b_512_ctrl: behavioural macro, array/queue reference model at the
// request level, and a negedge monitor that scores every cycle against it.
module tb_sram_150b_512_ctrl;

  localparam int DW    = 150;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int RD    = 4;

  logic          clk0 = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          clear_done;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;

  int checks = 0;
  int errors = 0;

  sram_150b_512_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)) dut (
    .clk0        (clk0),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .csb0        (csb0),
    .web0        (web0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0)
  );

  initial forever #5 clk0 = ~clk0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Macro model: samples pins at posedge, acts at the following negedge, and drives
  // garbage on dout0 shortly after each posedge to expose mistimed captures.
  logic [DW-1:0] ram [DEPTH];
  logic          m_csb, m_web;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  always begin
    @(posedge clk0);
    m_csb  = csb0;
    m_web  = web0;
    m_addr = addr0;
    m_din  = din0;
    #1 dout0 = rand_word();
    @(negedge clk0);
    if (!m_csb) begin
      if (!m_web) ram[m_addr] = m_din;
      else        dout0 = ram[m_addr];
    end
  end

  // Reference model: memory contents as of acceptance order, and the queue of owed responses.
  typedef struct {
    logic [DW-1:0] data;
    int            rdy;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] exp_mem [DEPTH];
  int            busy_cnt = 0;
  bit            done_exp = 1'b0;
  int            cyc = 0;
  bit            seen_reset = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = '0;
      exp_mem[i] = '0;
    end
  end

  always @(negedge clk0) begin
    bit   exp_ready;
    bit   exp_valid;
    exp_t head;
    cyc++;
    exp_ready = rst_n && (busy_cnt == 0) && (exp_q.size() < RD);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
    if (seen_reset) begin
      check_bit("req_ready", req_ready, exp_ready);
      check_bit("clear_busy", clear_busy, busy_cnt != 0);
      check_bit("clear_done", clear_done, done_exp);
      check_bit("rsp_valid", rsp_valid, exp_valid);
    end
    if (!rst_n) begin
      exp_q.delete();
      busy_cnt   = 0;
      done_exp   = 1'b0;
      seen_reset = 1'b1;
    end else if (seen_reset) begin
      if (exp_valid && rsp_ready) begin
        head = exp_q.pop_front();
        if (rsp_valid) check_word("rsp_rdata", rsp_rdata, head.data);
      end
      if (req_valid && exp_ready) begin
        if (req_we) exp_mem[req_addr] = req_wdata;
        else        exp_q.push_back('{exp_mem[req_addr], cyc + 3});
      end
      done_exp = (busy_cnt == 1);
      if (busy_cnt > 0) begin
        busy_cnt--;
      end else if (clear_start) begin
        busy_cnt = DEPTH;
        foreach (exp_mem[i]) exp_mem[i] = '0;
      end
    end
  end

  // Drives one request and holds it until the DUT takes it; returns at posedge+1.
  task automatic send(input logic we, input int a, input logic [DW-1:0] d);
    bit got;
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(a);
    req_wdata = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 2000) begin
      @(negedge clk0);
      got = req_ready;
      @(posedge clk0);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL req_timeout: got no accept in %0d cycles, required accept", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk0);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses pending, required 0", exp_q.size());
    end
  endtask

  logic [DW-1:0] w5;

  initial begin
    w5 = {{142{1'b1}}, 8'hA5};

    rst_n = 1'b0;
    repeat (3) @(posedge clk0);
    #1;
    check_bit("rst_csb0", csb0, 1'b1);
    check_bit("rst_web0", web0, 1'b1);
    check_word("rst_addr0", DW'(addr0), '0);
    check_word("rst_din0", din0, '0);
    check_bit("rst_rsp_valid", rsp_valid, 1'b0);
    check_bit("rst_req_ready", req_ready, 1'b0);
    check_bit("rst_clear_busy", clear_busy, 1'b0);
    rst_n = 1'b1;
    #1;
    check_bit("post_rst_req_ready", req_ready, 1'b1);
    @(posedge clk0);
    #1;

    // Preload, then write-then-read of address 5.
    for (int a = 0; a < 16; a++) send(1'b1, a, DW'(a));
    send(1'b1, 5, w5);
    send(1'b0, 5, '0);
    drain();
    send(1'b1, 5, DW'(5));

    // Streaming reads.
    rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) send(1'b0, a, '0);
    drain();

    // Backpressure: reads then writes offered against a full FIFO.
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_we    = (i >= 8);
      req_addr  = AW'(i);
      req_wdata = rand_word();
      @(posedge clk0);
      #1;
    end
    req_valid = 1'b0;
    check_bit("bp_req_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    drain();

    // Randomized mixed traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom % 3) != 0;
      req_we    = $urandom % 2;
      req_addr  = AW'($urandom_range(0, 31));
      req_wdata = rand_word();
      rsp_ready = ($urandom % 4) != 0;
      @(posedge clk0);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Clear: fill, start together with a write, re-pulse mid-clear.
    for (int a = 0; a < DEPTH; a++) send(1'b1, a, rand_word() | DW'(1));
    clear_start = 1'b1;
    send(1'b1, 7, w5);
    clear_start = 1'b0;
    repeat (100) @(posedge clk0);
    #1;
    clear_start = 1'b1;
    @(posedge clk0);
    #1;
    clear_start = 1'b0;
    begin
      int n;
      n = 0;
      while (clear_busy && n < 1000) begin
        @(posedge clk0);
        #1;
        n++;
      end
    end
    send(1'b0, 0, '0);
    send(1'b0, 255, '0);
    send(1'b0, 511, '0);
    send(1'b0, 7, '0);
    drain();

    // Reset with reads in flight.
    send(1'b1, 9, w5);
    send(1'b0, 9, '0);
    send(1'b0, 10, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk0);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk0);
    #1;
    send(1'b0, 9, '0);
    drain();
    repeat (4) @(posedge clk0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_150b_512_ctrl.md
# sram_150b_512_ctrl

Initiator-side controller for the 150-bit x 512-word single-port OpenRAM macro. It converts a valid/ready request stream into macro port pins: `csb0`, `web0`, `addr0`, `din0`. It captures `dout0` at the correct cycle and returns read data on a valid/ready response stream through a credit-protected FIFO. It also provides a whole-array clear sequencer. It sits between the core's memory client logic and the macro instance, sharing `clk0` with the macro.

## Interface

**Parameters**
- `DATA_WIDTH`, default 150: word width; must match the macro.
- `ADDR_WIDTH`, default 9: address width; `RAM_DEPTH = 1 << ADDR_WIDTH`.
- `RSP_DEPTH`, default 4: response FIFO entries; power of 2, at least 3.

**Ports**
- `clk0`, input, 1: single clock, shared with the macro.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: request accepted when high together with `req_valid`.
- `req_we`, input, 1: 1 = write, 0 = read.
- `req_addr`, input, `ADDR_WIDTH`: word address.
- `req_wdata`, input, `DATA_WIDTH`: write data.
- `rsp_valid`, output, 1: read data available.
- `rsp_ready`, input, 1: consumer pops the FIFO head.
- `rsp_rdata`, output, `DATA_WIDTH`: FIFO head data.
- `clear_start`, input, 1: pulse that starts the zero-fill of the whole array.
- `clear_busy`, output, 1: zero-fill in progress.
- `clear_done`, output, 1: one-cycle pulse when the zero-fill completes.
- `csb0`, output, 1: macro chip select, active-low, registered.
- `web0`, output, 1: macro write enable, active-low, registered.
- `addr0`, output, `ADDR_WIDTH`: macro address, registered.
- `din0`, output, `DATA_WIDTH`: macro write data, registered.
- `dout0`, input, `DATA_WIDTH`: macro read data.

## Operation

**Issue.** At most one macro access per cycle. All macro pins come straight from flops.
- Cycle with an accepted request: load `csb0=0`, `web0=!req_we`, `addr0=req_addr`, `din0=req_wdata`.
- Cycle with a clear step: load `csb0=0`, `web0=0`, `addr0=clear_ptr`, `din0=0`.
- Any other cycle: `csb0=1`, `web0=1`; `addr0`/`din0` hold their values.

**Ordering.** Accesses reach the macro in acceptance order. A read after a write to the same address returns the new data; the write commits at the macro negedge before the read is sampled.

**Credit counter.** `outstanding` ranges 0..`RSP_DEPTH`.
- +1 on an accepted read; −1 on a pop (`rsp_valid && rsp_ready`); both in one cycle leaves it unchanged.
- Writes take no credit and produce no response.

**Ready rule.** `req_ready = !clear_busy && (outstanding < RSP_DEPTH)`, independent of `req_we`.

**Read pipeline.** A 2-stage valid shift register tracks reads in flight. The stage-2 valid pushes the current `dout0` into the FIFO. The credit rule guarantees the FIFO never overflows; a push into a full FIFO is an assertion failure.

**Clear FSM.**
- IDLE: `clear_start` sampled high → CLEAR, `clear_ptr=0`.
- CLEAR: issue one write per cycle for `clear_ptr = 0..RAM_DEPTH-1`.
  - Leave CLEAR after issuing `RAM_DEPTH-1`.
  - Pulse `clear_done` for one cycle at the transition back to IDLE.
- `clear_start` while in CLEAR is ignored.
- Reads already in flight drain normally during CLEAR.
- `rsp_ready` backpressure does not stall CLEAR.

**Simultaneous request and `clear_start` in IDLE.** The request is accepted and issued first; clear steps begin the next cycle.

**Reset** (sampled `rst_n=0`) gives these values:
- `csb0=1`, `web0=1`, `addr0=0`, `din0=0`.
- `rsp_valid=0`, `outstanding=0`, FIFO empty, in-flight valids cleared.
- FSM in IDLE, `clear_busy=0`, `clear_done=0`, `req_ready=0` during reset.

Reads in flight when reset asserts are discarded. Macro contents are not affected by reset.

## Timing

**Read path.** Request accepted at posedge N:
- Pins are valid after posedge N.
- The macro samples them at posedge N+1 and drives `dout0` at negedge N+1.
- The controller captures `dout0` at posedge N+2; the macro drives X at N+2 plus its hold time, which is after the capture.
- `rsp_valid` is high in cycle N+2. Read latency is 2 cycles.

**Write path.** A write accepted at posedge N commits to the array at negedge N+1.

**Throughput.** Pop occurs at posedge N+3, so a read holds a credit for 3 cycles. With `RSP_DEPTH>=3` and `rsp_ready` held high, reads sustain 1 per cycle.

**Clear timing.** `clear_start` sampled at posedge N:
- `clear_busy` is high from N through N+`RAM_DEPTH`.
- Steps load at posedges N+1..N+`RAM_DEPTH`.
- `clear_done` is high in the cycle after posedge N+`RAM_DEPTH`.
- `req_ready` returns high in that same cycle, subject to credit.

## Test plan

- **Reset values.** Hold `rst_n=0` for 3 cycles → `csb0=1`, `web0=1`, `rsp_valid=0`, `req_ready=0`, `clear_busy=0`; after release, `req_ready=1`.
- **Write then read.** Write addr 5 = 150'h3FFF…A5, then read addr 5 on the next cycle → `rsp_rdata`=written value, `rsp_valid` 2 cycles after read acceptance.
- **Streaming reads.** Back-to-back reads of addrs 0..15, preloaded with data=addr, `rsp_ready=1` → 16 responses in order on consecutive cycles; `req_ready` never drops.
- **Backpressure.** `rsp_ready=0` with reads streaming → exactly 4 reads accepted, then `req_ready=0`. Releasing `rsp_ready` yields 4 responses in order, no loss or duplication. Writes are also blocked while the FIFO is full.
- **Clear.** Fill all addresses with nonzero data, pulse `clear_start` → `clear_busy` high for 512 cycles and `clear_done` high for one cycle. Reads of addrs 0, 255, 511 then return 0. A second `clear_start` mid-clear is ignored.
- **Reset mid-flight.** Issue 2 reads, then assert `rst_n=0` in the next cycle → no response ever appears, `outstanding=0`. A subsequent read of a previously written address returns the retained data.
